// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter.
// Instruction-fetch reads and data loads/stores share one RAM, with one
// transaction in flight at a time. When both requesters are valid in IDLE,
// the one not granted last time wins. A misaligned or out-of-range address
// returns an error response straight away and never touches the RAM.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready offered to the arbitration winner; handshake captured here
// ACCESS | one-cycle RAM command (mem_en high)
// WAIT   | MEM_LAT cycles of RAM latency; read data captured on the last one
// RESP   | one-cycle response to the owning requester
module mem_arbiter #(
    parameter int RAM_WORDS = 1024,
    parameter int MEM_LAT   = 1,
    localparam int AW       = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [31:0]   i_req_addr,
    output logic          i_rsp_valid,
    output logic [31:0]   i_rsp_data,
    output logic          i_rsp_err,

    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic [31:0]   d_req_addr,
    input  logic [31:0]   d_req_wdata,
    input  logic [3:0]    d_req_wstrb,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rsp_data,
    output logic          d_rsp_err,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic        SRC_I      = 1'b0;
    localparam logic        SRC_D      = 1'b1;
    localparam logic [2:0]  CNT_INIT   = 3'(MEM_LAT - 1);
    localparam logic [32:0] BYTE_LIMIT = 33'(RAM_WORDS) << 2;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic            grant_i;
    logic            grant_d;
    logic [31:0]     sel_addr;
    logic            addr_err;

    // Round-robin arbitration; only offered while IDLE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_req_valid && d_req_valid) begin
                if (last_grant_q == SRC_D) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (i_req_valid) begin
                grant_i = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // Address of the granted request and its alignment/range check.
    always_comb begin
        sel_addr = grant_d ? d_req_addr : i_req_addr;
        addr_err = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= BYTE_LIMIT);
    end

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        wstrb_d      = wstrb_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    last_grant_d = grant_d ? SRC_D : SRC_I;
                    owner_d      = grant_d ? SRC_D : SRC_I;
                    rsp_data_d   = 32'h0;
                    if (addr_err) begin
                        // Bad address: answer next cycle, leave the RAM port alone.
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        rsp_err_d  = 1'b0;
                        we_d       = grant_d & d_req_we;
                        wstrb_d    = (grant_d && d_req_we) ? d_req_wstrb : 4'b0000;
                        mem_addr_d = sel_addr[AW+1:2];
                        if (grant_d) begin
                            mem_wdata_d = d_req_wdata;
                        end
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (!we_q) begin
                        rsp_data_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                rsp_data_d = 32'h0;
                rsp_err_d  = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_D;
            owner_q      <= SRC_I;
            we_q         <= 1'b0;
            wstrb_q      <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            cnt_q        <= 3'd0;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            wstrb_q      <= wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // RAM command strobes exist only in ACCESS; address/wdata simply hold.
    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_we    = (state_q == ACCESS) && we_q;
        mem_wstrb = (state_q == ACCESS) ? wstrb_q : 4'b0000;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        busy      = (state_q != IDLE);
    end

    // Responses go only to the owner; data and err are zero whenever valid is low.
    always_comb begin
        i_rsp_valid = (state_q == RESP) && (owner_q == SRC_I);
        d_rsp_valid = (state_q == RESP) && (owner_q == SRC_D);
        i_rsp_data  = i_rsp_valid ? rsp_data_q : 32'h0;
        d_rsp_data  = d_rsp_valid ? rsp_data_q : 32'h0;
        i_rsp_err   = i_rsp_valid & rsp_err_q;
        d_rsp_err   = d_rsp_valid & rsp_err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 backed by a
// writable RAM model, one at MEM_LAT=3 backed by a read-only pipelined model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;

    // MEM_LAT = 1 instance
    logic        i_req_valid, i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid, i_rsp_err;
    logic [31:0] i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_rsp_valid, d_rsp_err;
    logic [31:0] d_rsp_data;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        busy;

    // MEM_LAT = 3 instance
    logic        x_i_req_valid, x_i_req_ready;
    logic [31:0] x_i_req_addr;
    logic        x_i_rsp_valid, x_i_rsp_err;
    logic [31:0] x_i_rsp_data;
    logic        x_d_req_valid, x_d_req_ready, x_d_req_we;
    logic [31:0] x_d_req_addr, x_d_req_wdata;
    logic [3:0]  x_d_req_wstrb;
    logic        x_d_rsp_valid, x_d_rsp_err;
    logic [31:0] x_d_rsp_data;
    logic        x_mem_en, x_mem_we;
    logic [9:0]  x_mem_addr;
    logic [31:0] x_mem_wdata, x_mem_rdata;
    logic [3:0]  x_mem_wstrb;
    logic        x_busy;

    logic [31:0] ram [0:1023];
    logic        ram_load;
    logic [31:0] x_p1, x_p2, x_p3;

    int n_pass;
    int n_total;

    mem_arbiter #(.RAM_WORDS(1024), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.RAM_WORDS(1024), .MEM_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(x_i_req_valid), .i_req_ready(x_i_req_ready), .i_req_addr(x_i_req_addr),
        .i_rsp_valid(x_i_rsp_valid), .i_rsp_data(x_i_rsp_data), .i_rsp_err(x_i_rsp_err),
        .d_req_valid(x_d_req_valid), .d_req_ready(x_d_req_ready), .d_req_we(x_d_req_we),
        .d_req_addr(x_d_req_addr), .d_req_wdata(x_d_req_wdata), .d_req_wstrb(x_d_req_wstrb),
        .d_rsp_valid(x_d_rsp_valid), .d_rsp_data(x_d_rsp_data), .d_rsp_err(x_d_rsp_err),
        .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
        .mem_wstrb(x_mem_wstrb), .mem_rdata(x_mem_rdata), .busy(x_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return (a == 10'd4) ? 32'hDEADBEEF : {16'hC0DE, 6'b0, a};
    endfunction

    // Writable RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int k = 0; k < 1024; k++) ram[k] <= init_val(10'(k));
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Read-only RAM with three cycles of latency.
    always @(posedge clk) begin
        x_p1 <= init_val(x_mem_addr);
        x_p2 <= x_p1;
        x_p3 <= x_p2;
    end
    assign x_mem_rdata = x_p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; ram_load = 1'b1;
        i_req_valid = 0; i_req_addr = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wstrb = 0;
        x_i_req_valid = 0; x_i_req_addr = 0;
        x_d_req_valid = 0; x_d_req_we = 0; x_d_req_addr = 0; x_d_req_wdata = 0; x_d_req_wstrb = 0;
        repeat (2) @(posedge clk);
        #2;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_i_rsp", {i_rsp_valid, i_rsp_err}, 0);
        chk("rst_d_rsp", {d_rsp_valid, d_rsp_err}, 0);
        chk("rst_i_data", i_rsp_data, 0);
        chk("rst_x_busy", x_busy, 0);
        chk("rst_x_mem", {x_mem_en, x_mem_we, x_mem_wstrb}, 0);
        chk("rst_x_wdata", x_mem_wdata, 0);
        chk("rst_x_rsp", {x_i_rsp_valid, x_i_rsp_err, x_d_rsp_valid, x_d_rsp_err}, 0);
        chk("rst_x_i_data", x_i_rsp_data, 0);

        rst_n = 1'b1; ram_load = 1'b0;

        // Tie after reset: instruction first, then data, then instruction again
        i_req_valid = 1; i_req_addr = 32'h0;
        d_req_valid = 1; d_req_addr = 32'h4;
        #1;
        chk("tie_i_ready", i_req_ready, 1);
        chk("tie_d_ready", d_req_ready, 0);
        step();
        chk("tie1_mem_en", mem_en, 1);
        chk("tie1_mem_addr", mem_addr, 0);
        chk("tie1_busy", busy, 1);
        chk("tie1_readys", {i_req_ready, d_req_ready}, 0);
        step();
        chk("tie1_wait_mem_en", mem_en, 0);
        step();
        chk("tie1_i_rsp_valid", i_rsp_valid, 1);
        chk("tie1_i_rsp_data", i_rsp_data, 32'hC0DE0000);
        chk("tie1_d_rsp_valid", d_rsp_valid, 0);
        step();
        chk("tie2_d_ready", d_req_ready, 1);
        chk("tie2_i_ready", i_req_ready, 0);
        step();
        chk("tie2_mem_en", mem_en, 1);
        chk("tie2_mem_addr", mem_addr, 1);
        step();
        step();
        chk("tie2_d_rsp_valid", d_rsp_valid, 1);
        chk("tie2_d_rsp_data", d_rsp_data, 32'hC0DE0001);
        chk("tie2_i_rsp_valid", i_rsp_valid, 0);
        step();
        chk("tie3_i_ready", i_req_ready, 1);
        chk("tie3_d_ready", d_req_ready, 0);
        step();
        i_req_valid = 0; d_req_valid = 0;
        #1;
        chk("tie3_mem_en", mem_en, 1);
        chk("tie3_mem_addr", mem_addr, 0);
        step();
        step();
        chk("tie3_i_rsp_valid", i_rsp_valid, 1);
        chk("tie3_d_rsp_valid", d_rsp_valid, 0);
        step();
        chk("tie_idle_busy", busy, 0);
        chk("tie_idle_d_rsp", d_rsp_valid, 0);
        step();

        // Single instruction read of RAM[4]; a data request that drops early is ignored
        i_req_valid = 1; i_req_addr = 32'h10;
        #1;
        chk("rd_i_ready", i_req_ready, 1);
        step();
        i_req_valid = 0;
        d_req_valid = 1; d_req_addr = 32'h20;
        #1;
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 4);
        chk("rd_d_ready_busy", d_req_ready, 0);
        step();
        d_req_valid = 0;
        #1;
        chk("rd_wait_rsp", i_rsp_valid, 0);
        step();
        chk("rd_i_rsp_valid", i_rsp_valid, 1);
        chk("rd_i_rsp_data", i_rsp_data, 32'hDEADBEEF);
        chk("rd_i_rsp_err", i_rsp_err, 0);
        step();
        chk("rd_idle_busy", busy, 0);
        chk("rd_no_d_rsp0", d_rsp_valid, 0);
        step();
        chk("rd_no_d_rsp1", d_rsp_valid, 0);

        // Byte store to word 2, lane 1
        d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h8;
        d_req_wdata = 32'h11223344; d_req_wstrb = 4'b0010;
        #1;
        chk("st_d_ready", d_req_ready, 1);
        step();
        d_req_valid = 0; d_req_we = 0; d_req_wdata = 0; d_req_wstrb = 0;
        #1;
        chk("st_mem_en", mem_en, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 2);
        chk("st_mem_wstrb", mem_wstrb, 4'b0010);
        chk("st_mem_wdata", mem_wdata, 32'h11223344);
        step();
        chk("st_wait_strobes", {mem_en, mem_we, mem_wstrb}, 0);
        chk("st_wdata_hold", mem_wdata, 32'h11223344);
        step();
        chk("st_d_rsp_valid", d_rsp_valid, 1);
        chk("st_d_rsp_data", d_rsp_data, 0);
        chk("st_d_rsp_err", d_rsp_err, 0);
        step();

        // Load back the stored word: only byte 1 changed
        d_req_valid = 1; d_req_addr = 32'h8;
        #1;
        chk("ld_d_ready", d_req_ready, 1);
        step();
        d_req_valid = 0;
        step();
        step();
        chk("ld_d_rsp_valid", d_rsp_valid, 1);
        chk("ld_d_rsp_data", d_rsp_data, 32'hC0DE3302);
        step();

        // Last valid word
        i_req_valid = 1; i_req_addr = 32'hFFC;
        #1;
        chk("top_i_ready", i_req_ready, 1);
        step();
        i_req_valid = 0;
        #1;
        chk("top_mem_addr", mem_addr, 32'h3FF);
        step();
        step();
        chk("top_i_rsp_data", i_rsp_data, 32'hC0DE03FF);
        chk("top_i_rsp_err", i_rsp_err, 0);
        step();

        // Misaligned data address
        d_req_valid = 1; d_req_addr = 32'h6;
        #1;
        chk("mis_d_ready", d_req_ready, 1);
        step();
        d_req_valid = 0;
        #1;
        chk("mis_d_rsp_valid", d_rsp_valid, 1);
        chk("mis_d_rsp_err", d_rsp_err, 1);
        chk("mis_d_rsp_data", d_rsp_data, 0);
        chk("mis_mem_en", mem_en, 0);
        chk("mis_mem_addr_hold", mem_addr, 32'h3FF);
        step();
        chk("mis_idle", {busy, mem_en, d_rsp_valid}, 0);

        // Out-of-range instruction address
        i_req_valid = 1; i_req_addr = 32'h1000;
        #1;
        chk("oor_i_ready", i_req_ready, 1);
        step();
        i_req_valid = 0;
        #1;
        chk("oor_i_rsp_valid", i_rsp_valid, 1);
        chk("oor_i_rsp_err", i_rsp_err, 1);
        chk("oor_i_rsp_data", i_rsp_data, 0);
        chk("oor_mem_en", mem_en, 0);
        chk("oor_d_rsp_valid", d_rsp_valid, 0);
        step();
        chk("oor_idle", {busy, mem_en, i_rsp_valid}, 0);

        // MEM_LAT=3: read RAM[4], response 5 cycles after handshake
        x_i_req_valid = 1; x_i_req_addr = 32'h10;
        #1;
        chk("l3_i_ready", x_i_req_ready, 1);
        step();
        x_i_req_valid = 0;
        #1;
        chk("l3_mem_en", x_mem_en, 1);
        chk("l3_mem_addr", x_mem_addr, 4);
        step();
        step();
        step();
        chk("l3_early_rsp", x_i_rsp_valid, 0);
        chk("l3_busy", x_busy, 1);
        step();
        chk("l3_i_rsp_valid", x_i_rsp_valid, 1);
        chk("l3_i_rsp_data", x_i_rsp_data, 32'hDEADBEEF);
        step();

        // MEM_LAT=3: reset one cycle after mem_en abandons the load
        x_d_req_valid = 1; x_d_req_addr = 32'h4;
        #1;
        chk("rw_d_ready", x_d_req_ready, 1);
        step();
        x_d_req_valid = 0;
        #1;
        chk("rw_mem_en", x_mem_en, 1);
        chk("rw_mem_addr", x_mem_addr, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rw_busy", x_busy, 0);
        chk("rw_mem_en", x_mem_en, 0);
        chk("rw_mem_addr", x_mem_addr, 0);
        chk("rw_rsp", {x_d_rsp_valid, x_d_rsp_err, x_i_rsp_valid}, 0);
        chk("rw_d_data", x_d_rsp_data, 0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rw_post_rsp", {x_d_rsp_valid, x_i_rsp_valid}, 0);
            chk("rw_post_busy", x_busy, 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
